mdu_pipe: RTL and testbench

- Parametrised multiply/divide unit with HI/LO registers for the pipelined MIPS core; successor to the single-cycle datapath's ALU-only arithmetic.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage.
- Models a fixed multi-cycle latency with a busy flag that the hazard unit uses to stall MDU-dependent instructions.
- Drives HI/LO continuously for MFHI/MFLO.

---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mdu_calc.sv | 74 +++++++
 rtl/mdu_pipe.sv | 95 +++++++++
 tb/tb_mdu_pipe.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings and sizing helpers for the multiply/divide unit.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } mdu_state_e;

    // Counter must hold N-1 for the longer of the two latencies; never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned mult_cycles,
                                              input int unsigned div_cycles);
        int unsigned m;
        m = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational result generator for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
module mdu_calc
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic [WIDTH-1:0]   b_safe;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   quo_u;
    logic [WIDTH-1:0]   rem_u;
    logic               div_zero;
    logic               div_ovf;

    assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    // A dummy divisor keeps the dividers free of X when b is zero; the result is discarded.
    assign div_zero = (b == '0);
    assign div_ovf  = (a == MOST_NEG) && (b == '1);
    assign b_safe   = div_zero ? ONE : b;
    assign quo_s    = $signed(a) / $signed(b_safe);
    assign rem_s    = $signed(a) % $signed(b_safe);
    assign quo_u    = a / b_safe;
    assign rem_u    = a % b_safe;

    always_comb begin
        res_hi = hi;
        res_lo = lo;
        case (op)
            MDU_MULT: begin
                res_hi = prod_s[2*WIDTH-1:WIDTH];
                res_lo = prod_s[WIDTH-1:0];
            end
            MDU_MULTU: begin
                res_hi = prod_u[2*WIDTH-1:WIDTH];
                res_lo = prod_u[WIDTH-1:0];
            end
            MDU_DIV: begin
                if (div_ovf) begin
                    res_hi = '0;
                    res_lo = MOST_NEG;
                end else if (!div_zero) begin
                    res_hi = rem_s;
                    res_lo = quo_s;
                end
            end
            MDU_DIVU: begin
                if (!div_zero) begin
                    res_hi = rem_u;
                    res_lo = quo_u;
                end
            end
            MDU_MTHI: res_hi = a;
            MDU_MTLO: res_lo = a;
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_pipe.sv
// Multi-cycle multiply/divide unit with HI/LO registers and a busy flag for hazard stalls.
module mdu_pipe
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);

    mdu_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] pend_hi;
    logic [WIDTH-1:0] pend_lo;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    mdu_calc #(
        .WIDTH (WIDTH)
    ) u_calc (
        .op     (op),
        .a      (a),
        .b      (b),
        .hi     (hi),
        .lo     (lo),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            MDU_MULT, MDU_MULTU: begin
                                pend_hi <= res_hi;
                                pend_lo <= res_lo;
                                cnt     <= CNT_W'(MULT_CYCLES - 1);
                                busy    <= 1'b1;
                                state   <= S_BUSY;
                            end
                            MDU_DIV, MDU_DIVU: begin
                                pend_hi <= res_hi;
                                pend_lo <= res_lo;
                                cnt     <= CNT_W'(DIV_CYCLES - 1);
                                busy    <= 1'b1;
                                state   <= S_BUSY;
                            end
                            MDU_MTHI: hi <= res_hi;
                            MDU_MTLO: lo <= res_lo;
                            default: ;
                        endcase
                    end
                end
                S_BUSY: begin
                    // Requests arriving here are dropped; the hazard unit should never issue them.
                    if (cnt == '0) begin
                        hi    <= pend_hi;
                        lo    <= pend_lo;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_pipe.sv
// Directed plus randomized checks of mdu_pipe against a 64-bit arithmetic reference model.
module tb_mdu_pipe;

    localparam int unsigned W  = 32;
    localparam int unsigned NM = 5;
    localparam int unsigned ND = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int tests  = 0;
    int failed = 0;

    logic [W-1:0] hi_m;
    logic [W-1:0] lo_m;

    mdu_pipe #(
        .WIDTH       (W),
        .MULT_CYCLES (NM),
        .DIV_CYCLES  (ND)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: what HI/LO should hold after an accepted op, from plain wide arithmetic.
    task automatic model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint          sx, sy, sq, sr;
        longint unsigned ux, uy, up;
        logic [63:0]     v;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            3'd0: begin v = sx * sy; hi_m = v[63:32]; lo_m = v[31:0]; end
            3'd1: begin up = ux * uy; v = up; hi_m = v[63:32]; lo_m = v[31:0]; end
            3'd2: if (y != 0) begin
                sq = sx / sy; sr = sx % sy;
                v = sq; lo_m = v[31:0];
                v = sr; hi_m = v[31:0];
            end
            3'd3: if (y != 0) begin
                v = ux / uy; lo_m = v[31:0];
                v = ux % uy; hi_m = v[31:0];
            end
            3'd4: hi_m = x;
            3'd5: lo_m = x;
            default: ;
        endcase
    endtask

    function automatic int latency(input logic [2:0] o);
        if (o <= 3'd1) return NM;
        if (o <= 3'd3) return ND;
        return 0;
    endfunction

    // Issue one request; optionally fire an MTLO into the 3rd busy cycle, which must be ignored.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input bit inject);
        int cycles;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        start = 1'b0; op = 3'd7; a = '0; b = '0;
        model(o, x, y);
        check({tag, ".done_low_e0"}, {63'd0, done}, 64'd0);
        cycles = 0;
        while (busy === 1'b1 && cycles < 100) begin
            cycles++;
            if (inject && cycles == 3) begin
                @(negedge clk);
                start = 1'b1; op = 3'd5; a = 32'h0000_AAAA;
            end
            @(posedge clk);
            #1;
            start = 1'b0; op = 3'd7; a = '0;
        end
        check({tag, ".busy_cycles"}, 64'(cycles), 64'(latency(o)));
        check({tag, ".done"}, {63'd0, done}, (latency(o) > 0) ? 64'd1 : 64'd0);
        check({tag, ".hi"}, {32'd0, hi}, {32'd0, hi_m});
        check({tag, ".lo"}, {32'd0, lo}, {32'd0, lo_m});
    endtask

    initial begin
        logic [2:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           seen_done;

        reset = 1'b1; start = 1'b0; op = 3'd7; a = '0; b = '0;
        hi_m = '0; lo_m = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset.busy", {63'd0, busy}, 64'd0);
        check("reset.done", {63'd0, done}, 64'd0);
        check("reset.hi", {32'd0, hi}, 64'd0);
        check("reset.lo", {32'd0, lo}, 64'd0);

        run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("mult.hi_const", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
        check("mult.lo_const", {32'd0, lo}, 64'h0000_0000_FFFF_FFFA);
        @(posedge clk);
        #1;
        check("mult.done_one_cycle", {63'd0, done}, 64'd0);

        run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        check("multu.hi_const", {32'd0, hi}, 64'h1);
        check("multu.lo_const", {32'd0, lo}, 64'hFFFF_FFFE);

        run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div.lo_const", {32'd0, lo}, 64'hFFFF_FFFD);
        check("div.hi_const", {32'd0, hi}, 64'hFFFF_FFFF);
        run_op("divu", 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("divu.lo_const", {32'd0, lo}, 64'h7FFF_FFFC);
        check("divu.hi_const", {32'd0, hi}, 64'h1);

        run_op("mtlo0", 3'd5, 32'd0, 32'd0, 1'b0);
        run_op("mthi", 3'd4, 32'h1234_5678, 32'd0, 1'b0);
        run_op("div0", 3'd2, 32'd5, 32'd0, 1'b0);
        check("div0.hi_const", {32'd0, hi}, 64'h1234_5678);
        check("div0.lo_const", {32'd0, lo}, 64'd0);

        run_op("ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        check("ovf.lo_const", {32'd0, lo}, 64'h8000_0000);
        check("ovf.hi_const", {32'd0, hi}, 64'd0);

        run_op("nop6", 3'd6, 32'hDEAD_BEEF, 32'd1, 1'b0);
        run_op("nop7", 3'd7, 32'hDEAD_BEEF, 32'd1, 1'b0);

        // Abort: reset lands in the 3rd busy cycle of a MULT.
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd7; b = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("abort.busy_before", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        hi_m = '0; lo_m = '0;
        check("abort.busy", {63'd0, busy}, 64'd0);
        check("abort.done", {63'd0, done}, 64'd0);
        check("abort.hi", {32'd0, hi}, 64'd0);
        check("abort.lo", {32'd0, lo}, 64'd0);
        seen_done = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || hi !== '0 || lo !== '0) seen_done++;
        end
        check("abort.no_late_write", 64'(seen_done), 64'd0);

        // Back-to-back: second MULT issued in the cycle busy first drops.
        run_op("b2b_first", 3'd0, 32'd1000, 32'hFFFF_FF9C, 1'b0);
        run_op("b2b_second", 3'd0, 32'h0001_0000, 32'h0001_0000, 1'b0);

        for (int i = 0; i < 30; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            run_op($sformatf("rand%0d", i), ro, ra, rb, ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
